// File: rtl/board_state.sv
// Sokoban board state: 20x15 cell store, player/box tracking, move feedback and level loader.
// Optional MOVE_COUNT_EN builds a saturating move counter on move_count.
module board_state #(
    parameter int COLS = 20,
    parameter int ROWS = 15
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ld_map_0,
    input  logic       ld_map_1,
    input  logic       ld_map_2,
    input  logic       ld_map_3,
    input  logic       ld_map_4,
    input  logic       ld_map_5,
    input  logic       ld_map_6,
    input  logic       ld_map_7,
    input  logic       reset_valid,
    input  logic       check_char,
    input  logic       check_box,
    input  logic       update_box,
    input  logic       update_char,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    output logic       key_pressed,
    output logic [2:0] rom_level,
    output logic [8:0] rom_addr,
    input  logic [2:0] rom_data,
    output logic       char_empty,
    output logic       char_obs,
    output logic       char_box,
    output logic       box_empty,
    output logic       win,
    output logic [4:0] char_x,
    output logic [3:0] char_y,
    output logic [4:0] box_x,
    output logic [3:0] box_y,
    output logic [9:0] move_count
);
    // state  | meaning
    // S_IDLE | board playable, waiting for a level-load request
    // S_LOAD | streaming 300 cells from the level ROM, strobes ignored
    // S_DONE | level loaded, waiting for all ld_map_* to drop
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    localparam int              CELLS       = COLS * ROWS;
    localparam logic signed [5:0] COLS_S    = 6'(COLS);
    localparam logic signed [4:0] ROWS_S    = 5'(ROWS);
    localparam logic [4:0]      X_LAST      = 5'(COLS - 1);
    localparam logic [1:0]      CONT_FLOOR  = 2'd0;
    localparam logic [1:0]      CONT_WALL   = 2'd1;
    localparam logic [1:0]      CONT_BOX    = 2'd2;
    localparam logic [1:0]      CONT_PLAYER = 2'd3;
    localparam logic [2:0]      OFF_CELL    = 3'b001;

    state_t            state, state_nxt;
    dir_t              dir;
    logic [2:0]        board [ROWS][COLS];
    logic [7:0]        ld_req;
    logic [2:0]        ld_sel;
    logic [8:0]        cnt;
    logic [4:0]        wx;
    logic [3:0]        wy;
    logic [8:0]        misplaced;
    logic              loaded;
    logic              load_start, load_last, strobe_ok;
    logic signed [5:0] dx, t1x, t2x;
    logic signed [4:0] dy, t1y, t2y;
    logic              on1, on2;
    logic [2:0]        cell1, cell2;

    assign ld_req      = {ld_map_7, ld_map_6, ld_map_5, ld_map_4,
                          ld_map_3, ld_map_2, ld_map_1, ld_map_0};
    assign key_pressed = key_up | key_down | key_left | key_right;
    assign load_start  = (state == S_IDLE) && (|ld_req);
    assign load_last   = (cnt == 9'(CELLS));
    assign strobe_ok   = (state != S_LOAD) && !load_start;
    assign rom_addr    = (cnt >= 9'(CELLS)) ? 9'(CELLS - 1) : cnt;

    always_comb begin
        ld_sel = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (ld_req[k]) ld_sel = 3'(k);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (|ld_req)   state_nxt = S_LOAD;
            S_LOAD:  if (load_last) state_nxt = S_DONE;
            S_DONE:  if (!(|ld_req)) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Targets use signed coordinates so a step off the left/top edge goes negative.
    always_comb begin
        dx = 6'sd0;
        dy = 5'sd0;
        case (dir)
            DIR_UP:    dy = -5'sd1;
            DIR_DOWN:  dy = 5'sd1;
            DIR_LEFT:  dx = -6'sd1;
            DIR_RIGHT: dx = 6'sd1;
            default:   dy = -5'sd1;
        endcase
    end

    assign t1x   = $signed({1'b0, char_x}) + dx;
    assign t1y   = $signed({1'b0, char_y}) + dy;
    assign t2x   = t1x + dx;
    assign t2y   = t1y + dy;
    assign on1   = !t1x[5] && (t1x < COLS_S) && !t1y[4] && (t1y < ROWS_S);
    assign on2   = !t2x[5] && (t2x < COLS_S) && !t2y[4] && (t2y < ROWS_S);
    assign cell1 = on1 ? board[t1y[3:0]][t1x[4:0]] : OFF_CELL;
    assign cell2 = on2 ? board[t2y[3:0]][t2x[4:0]] : OFF_CELL;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dir        <= DIR_UP;
            cnt        <= '0;
            wx         <= '0;
            wy         <= '0;
            rom_level  <= '0;
            misplaced  <= '0;
            loaded     <= 1'b0;
            win        <= 1'b0;
            char_empty <= 1'b0;
            char_obs   <= 1'b0;
            char_box   <= 1'b0;
            box_empty  <= 1'b0;
            char_x     <= '0;
            char_y     <= '0;
            box_x      <= '0;
            box_y      <= '0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) board[r][c] <= '0;
            end
        end else begin
            if (key_up)         dir <= DIR_UP;
            else if (key_down)  dir <= DIR_DOWN;
            else if (key_left)  dir <= DIR_LEFT;
            else if (key_right) dir <= DIR_RIGHT;

            win <= loaded && (misplaced == 9'd0);

            if (load_start) begin
                rom_level  <= ld_sel;
                cnt        <= '0;
                wx         <= '0;
                wy         <= '0;
                misplaced  <= '0;
                loaded     <= 1'b0;
                char_empty <= 1'b0;
                char_obs   <= 1'b0;
                char_box   <= 1'b0;
                box_empty  <= 1'b0;
            end else if (state == S_LOAD) begin
                cnt <= cnt + 9'd1;
                // ROM data lags the address by one cycle, so cnt==k writes cell k-1.
                if (cnt != 9'd0) begin
                    if (rom_data[1:0] == CONT_PLAYER) begin
                        board[wy][wx] <= {rom_data[2], CONT_FLOOR};
                        char_x        <= wx;
                        char_y        <= wy;
                    end else begin
                        board[wy][wx] <= rom_data;
                    end
                    if (rom_data == {1'b0, CONT_BOX}) misplaced <= misplaced + 9'd1;
                    if (wx == X_LAST) begin
                        wx <= '0;
                        wy <= wy + 4'd1;
                    end else begin
                        wx <= wx + 5'd1;
                    end
                end
                if (load_last) loaded <= 1'b1;
            end else begin
                if (reset_valid) begin
                    char_empty <= 1'b0;
                    char_obs   <= 1'b0;
                    char_box   <= 1'b0;
                    box_empty  <= 1'b0;
                end
                if (check_char) begin
                    char_obs   <= (cell1[1:0] == CONT_WALL);
                    char_box   <= (cell1[1:0] == CONT_BOX);
                    char_empty <= (cell1[1:0] != CONT_WALL) && (cell1[1:0] != CONT_BOX);
                end
                if (check_box) box_empty <= on2 && (cell2[1:0] == CONT_FLOOR);
                if (update_box) begin
                    if (on1) board[t1y[3:0]][t1x[4:0]] <= {cell1[2], CONT_FLOOR};
                    if (on2) board[t2y[3:0]][t2x[4:0]] <= {cell2[2], CONT_BOX};
                    misplaced <= misplaced + 9'(cell1[2]) - 9'(cell2[2]);
                    box_x     <= t2x[4:0];
                    box_y     <= t2y[3:0];
                end else if (update_char) begin
                    char_x <= t1x[4:0];
                    char_y <= t1y[3:0];
                end
            end
        end
    end

`ifdef MOVE_COUNT_EN
    logic [9:0] moves;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)                 moves <= '0;
        else if (load_start)         moves <= '0;
        else if (strobe_ok && update_char && !update_box && (moves != 10'd999))
                                     moves <= moves + 10'd1;
    end

    assign move_count = moves;
`else
    assign move_count = 10'd0;
`endif

endmodule

// File: tb/tb_board_state.sv
// Randomized scoreboard bench for board_state against a board-level reference model.
module tb_board_state;
    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       ld_map_0 = 0, ld_map_1 = 0, ld_map_2 = 0, ld_map_3 = 0;
    logic       ld_map_4 = 0, ld_map_5 = 0, ld_map_6 = 0, ld_map_7 = 0;
    logic       reset_valid = 0, check_char = 0, check_box = 0, update_box = 0, update_char = 0;
    logic       key_up = 0, key_down = 0, key_left = 0, key_right = 0;
    logic       key_pressed;
    logic [2:0] rom_level;
    logic [8:0] rom_addr;
    logic [2:0] rom_data = 3'd0;
    logic       char_empty, char_obs, char_box, box_empty, win;
    logic [4:0] char_x, box_x;
    logic [3:0] char_y, box_y;
    logic [9:0] move_count;

    board_state dut (
        .clock(clock), .resetn(resetn),
        .ld_map_0(ld_map_0), .ld_map_1(ld_map_1), .ld_map_2(ld_map_2), .ld_map_3(ld_map_3),
        .ld_map_4(ld_map_4), .ld_map_5(ld_map_5), .ld_map_6(ld_map_6), .ld_map_7(ld_map_7),
        .reset_valid(reset_valid), .check_char(check_char), .check_box(check_box),
        .update_box(update_box), .update_char(update_char),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .key_pressed(key_pressed), .rom_level(rom_level), .rom_addr(rom_addr), .rom_data(rom_data),
        .char_empty(char_empty), .char_obs(char_obs), .char_box(char_box), .box_empty(box_empty),
        .win(win), .char_x(char_x), .char_y(char_y), .box_x(box_x), .box_y(box_y),
        .move_count(move_count)
    );

    always #5 clock = ~clock;

    typedef enum int {S_CE, S_CO, S_CB, S_BE, S_WIN, S_CX, S_CY, S_BX, S_BY,
                      S_MC, S_LVL, S_ADDR, S_KEYP} sig_e;
    typedef struct {
        string name;
        sig_e  sel;
        int    val;
        int    due;
    } exp_t;

    exp_t q[$];
    exp_t keep_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    logic [2:0] rom [8][300];
    int mcont [300];
    int mgoal [300];
    int px, py, bx, by, mis, moves, mdir;
    bit mloaded;

    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock) rom_data <= (rom_addr < 9'd300) ? rom[rom_level][rom_addr] : 3'd0;

    function automatic int sig_val(sig_e s);
        case (s)
            S_CE:   return int'(char_empty);
            S_CO:   return int'(char_obs);
            S_CB:   return int'(char_box);
            S_BE:   return int'(box_empty);
            S_WIN:  return int'(win);
            S_CX:   return int'(char_x);
            S_CY:   return int'(char_y);
            S_BX:   return int'(box_x);
            S_BY:   return int'(box_y);
            S_MC:   return int'(move_count);
            S_LVL:  return int'(rom_level);
            S_ADDR: return int'(rom_addr);
            default: return int'(key_pressed);
        endcase
    endfunction

    // Monitor: every negedge, compare all expectations due this cycle.
    always @(negedge clock) begin
        keep_q = {};
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].due == cyc) begin
                checks++;
                if (sig_val(q[i].sel) != q[i].val) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got=%0d exp=%0d", q[i].name, cyc,
                             sig_val(q[i].sel), q[i].val);
                end
            end else if (q[i].due < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s missed due=%0d", q[i].name, q[i].due);
            end else begin
                keep_q.push_back(q[i]);
            end
        end
        q = keep_q;
    end

    task automatic push(input string n, input sig_e s, input int v, input int d);
        exp_t e;
        e.name = n; e.sel = s; e.val = v; e.due = d;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic int exp_mc();
`ifdef MOVE_COUNT_EN
        return (moves > 999) ? 999 : moves;
`else
        return 0;
`endif
    endfunction

    function automatic bit onb(input int x, input int y);
        return (x >= 0) && (x < 20) && (y >= 0) && (y < 15);
    endfunction

    function automatic int content_at(input int x, input int y);
        if (!onb(x, y)) return 1;
        return mcont[y*20 + x];
    endfunction

    function automatic int model_win();
        return (mloaded && mis == 0) ? 1 : 0;
    endfunction

    task automatic push_flags(input int ce, input int co, input int cb, input int be, input int d);
        push("char_empty", S_CE, ce, d);
        push("char_obs",   S_CO, co, d);
        push("char_box",   S_CB, cb, d);
        push("box_empty",  S_BE, be, d);
    endtask

    task automatic push_all_zero(input int d);
        push_flags(0, 0, 0, 0, d);
        push("rst_win", S_WIN, 0, d);
        push("rst_char_x", S_CX, 0, d);
        push("rst_char_y", S_CY, 0, d);
        push("rst_box_x", S_BX, 0, d);
        push("rst_box_y", S_BY, 0, d);
        push("rst_move_count", S_MC, 0, d);
        push("rst_rom_level", S_LVL, 0, d);
        push("rst_rom_addr", S_ADDR, 0, d);
        push("rst_key_pressed", S_KEYP, 0, d);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 300; i++) begin mcont[i] = 0; mgoal[i] = 0; end
        px = 0; py = 0; bx = 0; by = 0; mis = 0; moves = 0; mdir = 0; mloaded = 0;
    endtask

    task automatic model_load(input int lvl);
        int c;
        mis = 0;
        for (int i = 0; i < 300; i++) begin
            c = int'(rom[lvl][i][1:0]);
            mgoal[i] = int'(rom[lvl][i][2]);
            if (c == 3) begin px = i % 20; py = i / 20; c = 0; end
            if (c == 2 && mgoal[i] == 0) mis++;
            mcont[i] = c;
        end
        mloaded = 1;
        moves = 0;
    endtask

    task automatic set_cell(input int lvl, input int x, input int y, input int g, input int c);
        rom[lvl][y*20 + x] = 3'(g*4 + c);
    endtask

    task automatic gen_level(input int lvl, input bit nomis);
        int r, c, g;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            c = (r < 2) ? 1 : (r == 2) ? 2 : 0;
            g = ($urandom_range(0, 7) == 0) ? 1 : 0;
            if (nomis && c == 2) g = 1;
            rom[lvl][i] = 3'(g*4 + c);
        end
    endtask

    task automatic set_ld(input logic [7:0] m);
        {ld_map_7, ld_map_6, ld_map_5, ld_map_4, ld_map_3, ld_map_2, ld_map_1, ld_map_0} = m;
    endtask

    task automatic strobe(input int w);
        case (w)
            0: check_char = 1;
            1: check_box = 1;
            2: update_box = 1;
            3: update_char = 1;
            default: reset_valid = 1;
        endcase
        step();
        {check_char, check_box, update_box, update_char, reset_valid} = '0;
    endtask

    task automatic load_level(input logic [7:0] mask, input int abort);
        int c, lvl;
        lvl = 0;
        for (int k = 7; k >= 0; k--) if (mask[k]) lvl = k;
        c = cyc;
        set_ld(mask);
        push("rom_level", S_LVL, lvl, c + 1);
        push("rom_addr_first", S_ADDR, 0, c + 1);
        push_flags(0, 0, 0, 0, c + 1);
        push("win_load_clear", S_WIN, 0, c + 2);
        while (cyc < c + 10) step();
        push_flags(0, 0, 0, 0, cyc + 1);
        check_char = 1; check_box = 1;
        step();
        check_char = 0; check_box = 0;
        if (abort > 0) begin
            while (cyc < c + abort - 1) step();
            push("rom_addr_pre_abort", S_ADDR, abort - 2, cyc);
            step();
            resetn = 0;
            push_all_zero(cyc);
            set_ld(8'h00);
            step(); step();
            resetn = 1;
            step();
            model_reset();
            return;
        end
        push("rom_addr_mid", S_ADDR, 150, c + 151);
        push("rom_addr_last", S_ADDR, 299, c + 300);
        model_load(lvl);
        push("load_char_x", S_CX, px, c + 302);
        push("load_char_y", S_CY, py, c + 302);
        push("win_before_done", S_WIN, 0, c + 302);
        push("win_after_load", S_WIN, model_win(), c + 303);
        while (cyc < c + 305) step();
        set_ld(8'h00);
        step(); step();
    endtask

    task automatic do_move(input logic [3:0] m);
        int dx, dy, t1x, t1y, t2x, t2y, c1, i1, i2, wold;
        bit be;
        {key_up, key_down, key_left, key_right} = m;
        push("key_pressed", S_KEYP, 1, cyc);
        step();
        {key_up, key_down, key_left, key_right} = '0;
        if (m[3]) mdir = 0; else if (m[2]) mdir = 1; else if (m[1]) mdir = 2; else mdir = 3;
        dx = (mdir == 2) ? -1 : (mdir == 3) ? 1 : 0;
        dy = (mdir == 0) ? -1 : (mdir == 1) ? 1 : 0;
        t1x = px + dx; t1y = py + dy; t2x = px + 2*dx; t2y = py + 2*dy;
        c1 = content_at(t1x, t1y);
        push("cc_empty", S_CE, (c1 == 0) ? 1 : 0, cyc + 1);
        push("cc_obs",   S_CO, (c1 == 1) ? 1 : 0, cyc + 1);
        push("cc_box",   S_CB, (c1 == 2) ? 1 : 0, cyc + 1);
        strobe(0);
        be = onb(t2x, t2y) && (content_at(t2x, t2y) == 0);
        push("cb_box_empty", S_BE, be ? 1 : 0, cyc + 1);
        strobe(1);
        if (c1 == 2 && be) begin
            wold = model_win();
            i1 = t1y*20 + t1x; i2 = t2y*20 + t2x;
            mis = mis + mgoal[i1] - mgoal[i2];
            mcont[i1] = 0; mcont[i2] = 2;
            bx = t2x; by = t2y;
            push("box_x", S_BX, bx, cyc + 1);
            push("box_y", S_BY, by, cyc + 1);
            push("win_lag", S_WIN, wold, cyc + 1);
            push("win_push", S_WIN, model_win(), cyc + 2);
            strobe(2);
        end
        if (c1 == 0 || (c1 == 2 && be)) begin
            px = t1x; py = t1y; moves++;
            push("char_x", S_CX, px, cyc + 1);
            push("char_y", S_CY, py, cyc + 1);
            push("move_count", S_MC, exp_mc(), cyc + 1);
            strobe(3);
        end
        push_flags(0, 0, 0, 0, cyc + 1);
        push("win_hold", S_WIN, model_win(), cyc + 1);
        push("char_x_hold", S_CX, px, cyc + 1);
        strobe(4);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        for (int l = 0; l < 8; l++) gen_level(l, 0);
        step(); step();
        push_all_zero(cyc);
        step();
        resetn = 1;
        step();

        // level 2, every box on a goal: win after load; lowest request wins
        gen_level(2, 1);
        set_cell(2, 3, 4, 0, 3);
        set_cell(2, 5, 4, 1, 2);
        load_level(8'hA4, 0);

        // wall to the right
        gen_level(1, 0);
        set_cell(1, 3, 4, 0, 3);
        set_cell(1, 4, 4, 0, 1);
        load_level(8'h02, 0);
        do_move(4'b0001);

        // winning push onto goal
        gen_level(3, 1);
        set_cell(3, 3, 4, 0, 3);
        set_cell(3, 4, 4, 0, 2);
        set_cell(3, 5, 4, 1, 0);
        load_level(8'h08, 0);
        do_move(4'b0001);

        // blocked push: box behind box
        gen_level(4, 0);
        set_cell(4, 3, 4, 0, 3);
        set_cell(4, 4, 4, 0, 2);
        set_cell(4, 5, 4, 0, 2);
        load_level(8'h10, 0);
        do_move(4'b0001);
        do_move(4'b0001);

        // left edge, then box against the edge, then top edge
        gen_level(5, 0);
        set_cell(5, 0, 0, 0, 3);
        load_level(8'h20, 0);
        do_move(4'b0010);
        gen_level(6, 0);
        set_cell(6, 1, 0, 0, 3);
        set_cell(6, 0, 0, 0, 2);
        load_level(8'h40, 0);
        do_move(4'b0010);
        do_move(4'b1000);

        // reset mid-load, then a clean reload
        gen_level(0, 0);
        set_cell(0, $urandom_range(0, 19), $urandom_range(0, 14), 0, 3);
        load_level(8'h01, 150);
        load_level(8'h01, 0);
        for (int i = 0; i < 15; i++) do_move(4'($urandom_range(1, 15)));

        // sparse random level and a longer random walk
        for (int i = 0; i < 300; i++) rom[7][i] = ($urandom_range(0, 5) == 0) ? 3'd2 : 3'd0;
        for (int i = 0; i < 300; i++) if ($urandom_range(0, 6) == 0) rom[7][i][2] = 1'b1;
        set_cell(7, $urandom_range(2, 17), $urandom_range(2, 12), 0, 3);
        load_level(8'h80, 0);
        for (int i = 0; i < 60; i++) do_move(4'($urandom_range(1, 15)));

        step(); step(); step();
        for (int i = 0; i < q.size(); i++) begin
            checks++;
            failures++;
            $display("FAIL %s never_checked due=%0d", q[i].name, q[i].due);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
